// File: rtl/instr_imm_split_stage_pkg.sv
// Shared ISA field positions, widths, state encoding and bundles
// for the immediate-split decode stage.
package instr_imm_split_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 17;
    localparam int PC_W    = 32;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 28;
    localparam int I27_BIT = 27;
    localparam int RS_HI   = 26;
    localparam int RS_LO   = 22;
    localparam int RT_HI   = 21;
    localparam int RT_LO   = 17;
    localparam int IMM_HI  = 16;
    localparam int OFS_HI  = 15;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]       opcode;
        logic             i27;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [IMM_W-1:0] i_type;
        logic [IMM_W-1:0] mem_type;
    } fields_t;

    typedef struct packed {
        fields_t         f;
        logic [PC_W-1:0] pc;
    } entry_t;

endpackage

// File: rtl/instr_imm_split_stage_if.sv
// Fetch-side and operand-side handshake bundle for the
// immediate-split stage; master drives, slave is the stage.
interface instr_imm_split_stage_if
    import instr_imm_split_stage_pkg::*;
();

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_in;

    logic               out_valid;
    logic               out_ready;
    logic [3:0]         opcode;
    logic               I27;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [IMM_W-1:0]   I_type;
    logic [IMM_W-1:0]   mem_type;
    logic [PC_W-1:0]    pc_out;

    modport master (
        output in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, opcode, I27,
        input  rs, rt, I_type, mem_type, pc_out
    );

    modport slave (
        input  in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, opcode, I27,
        output rs, rt, I_type, mem_type, pc_out
    );

endinterface

// File: rtl/instr_imm_split_stage_field_split.sv
// Pure combinational split of a raw instruction into
// opcode, register and both immediate candidates.
module instr_field_split
    import instr_imm_split_stage_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output fields_t            fields
);

    always_comb begin
        fields.opcode   = instr[OPC_HI:OPC_LO];
        fields.i27      = instr[I27_BIT];
        fields.rs       = instr[RS_HI:RS_LO];
        fields.rt       = instr[RT_HI:RT_LO];
        fields.i_type   = instr[IMM_HI:0];
        fields.mem_type = {instr[OFS_HI], instr[OFS_HI:0]};
    end

endmodule

// File: rtl/instr_imm_split_stage.sv
// Two-entry skid-buffered decode stage producing the
// immediate mux inputs; ready and valid are registered.
module instr_imm_split_stage
    import instr_imm_split_stage_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic flush,
    instr_imm_split_stage_if.slave bus
);

    state_t  state;
    entry_t  main_q;
    entry_t  skid_q;
    entry_t  incoming;
    fields_t split;
    logic    in_rdy;
    logic    out_vld;
    logic    in_xfer;
    logic    out_xfer;

    instr_field_split u_split (
        .instr  (bus.instr),
        .fields (split)
    );

    assign incoming = {split, bus.pc_in};
    assign in_xfer  = bus.in_valid & in_rdy;
    assign out_xfer = out_vld & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= incoming;
                        state   <= ST_ONE;
                        out_vld <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= incoming;
                    end else if (in_xfer) begin
                        skid_q <= incoming;
                        state  <= ST_TWO;
                        in_rdy <= 1'b0;
                    end else if (out_xfer) begin
                        state   <= ST_EMPTY;
                        out_vld <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // skid entry is older than anything fetch can send next
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= ST_ONE;
                        in_rdy <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    in_rdy  <= 1'b1;
                    out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.opcode    = main_q.f.opcode;
    assign bus.I27       = main_q.f.i27;
    assign bus.rs        = main_q.f.rs;
    assign bus.rt        = main_q.f.rt;
    assign bus.I_type    = main_q.f.i_type;
    assign bus.mem_type  = main_q.f.mem_type;
    assign bus.pc_out    = main_q.pc;

endmodule

// File: tb/tb_instr_imm_split_stage.sv
// Directed and random checks of the immediate-split stage
// against a queue model with arithmetic field extraction.
module tb_instr_imm_split_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   failures;
    int   xfers;
    bit   zf;
    item_t q[$];

    instr_imm_split_stage_if bus ();

    instr_imm_split_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] mt;
        chk("in_ready", {31'd0, bus.in_ready}, (q.size() < 2) ? 1 : 0);
        chk("out_valid", {31'd0, bus.out_valid}, (q.size() > 0) ? 1 : 0);
        if (q.size() > 0 || zf) begin
            ins = (q.size() > 0) ? q[0].instr : 32'd0;
            pc  = (q.size() > 0) ? q[0].pc : 32'd0;
            mt  = ins % 65536;
            if (mt >= 32768) mt = mt + 65536;
            chk("opcode", {28'd0, bus.opcode}, ins / (2 ** 28));
            chk("I27", {31'd0, bus.I27}, (ins / (2 ** 27)) % 2);
            chk("rs", {27'd0, bus.rs}, (ins / (2 ** 22)) % 32);
            chk("rt", {27'd0, bus.rt}, (ins / (2 ** 17)) % 32);
            chk("I_type", {15'd0, bus.I_type}, ins % (2 ** 17));
            chk("mem_type", {15'd0, bus.mem_type}, mt);
            chk("pc_out", bus.pc_out, pc);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy,
                        input logic fl, input logic rn);
        bit m_in;
        bit m_out;
        item_t it;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc_in     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        rst_n         = rn;
        #1;
        if (bus.out_valid === 1'b1 && ordy) xfers++;
        m_in  = v && (q.size() < 2);
        m_out = ordy && (q.size() > 0);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            zf = 1;
        end else if (fl) begin
            q.delete();
            zf = 0;
        end else begin
            if (m_out) void'(q.pop_front());
            if (m_in) begin
                it.instr = ins;
                it.pc    = pc;
                q.push_back(it);
                zf = 0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        xfers    = 0;
        zf       = 0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.pc_in     = '0;
        bus.out_ready = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;

        step(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        step(1'b1, 32'h1800_8004, 32'h100, 1'b1, 1'b0, 1'b1);
        chk("split_i27", {31'd0, bus.I27}, 32'd1);
        chk("split_itype", {15'd0, bus.I_type}, 32'h0_8004);
        chk("split_memtype", {15'd0, bus.mem_type}, 32'h1_8004);
        step(1'b1, 32'h1000_0004, 32'h104, 1'b1, 1'b0, 1'b1);
        chk("split2_memtype", {15'd0, bus.mem_type}, 32'd4);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hA000_0000 + i, 32'h200 + 4 * i, 1'b0, 1'b0, 1'b1);
        chk("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold", bus.pc_out, 32'h200);
        step(1'b1, 32'hA000_0002, 32'h208, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        xfers = 0;
        for (int i = 0; i < 11; i++)
            step(i < 10, $urandom, 32'h300 + 4 * i, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("throughput", xfers, 32'd10);

        step(1'b1, 32'h5555_1111, 32'h400, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5555_2222, 32'h404, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5555_3333, 32'h408, 1'b0, 1'b1, 1'b1);
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 32'h6666_1111, 32'h500, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h6666_2222, 32'h504, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_pc", bus.pc_out, 32'd0);
        step(1'b1, 32'h7FFF_FFFF, 32'h600, 1'b0, 1'b0, 1'b1);
        chk("post_rst_latency", {31'd0, bus.out_valid}, 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 63) != 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
